// File: rtl/morse_symbol_decoder.sv
// morse_symbol_decoder
//   Groups Morse dots/dashes from the input processor into one letter and
//   decodes it to uppercase ASCII (A-Z, 0-9) when a short space arrives.
//   Optional feature macro: MORSE_WORD_SPACE_EN (emit 0x20 after WORD_GAP
//   consecutive spaces following a letter).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   sym_in[1:0]     00 dot, 01 dash, 11 short space, 10 ignored
//   sym_valid       sym_in qualifier
//   char_out[7:0]   decoded character, held between pulses
//   char_valid      one-cycle pulse, char_out valid
//   char_err        pulse with char_valid for undecodable/overflowed letters
//   sym_count[2:0]  symbols currently buffered
//   busy            letter being collected (COLLECT or OVERFLOW)
module morse_symbol_decoder #(
  parameter int unsigned MAX_SYMS = 5,
  parameter int unsigned WORD_GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sym_in,
  input  logic       sym_valid,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       char_err,
  output logic [2:0] sym_count,
  output logic       busy
);

  localparam int unsigned CNT_W = 3;
  localparam logic [7:0]  CH_ERR = 8'h3F;

  if (MAX_SYMS < 1 || MAX_SYMS > 7 || WORD_GAP < 2 || WORD_GAP > 15) begin : g_param_check
    $error("morse_symbol_decoder: MAX_SYMS or WORD_GAP out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_OVERFLOW, S_GAP} state_t;

  state_t               state_q, state_d;
  logic [MAX_SYMS-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic [7:0]           pend_char_q, pend_char_d;
  logic                 pend_err_q, pend_err_d;
  logic [7:0]           dec_char;
  logic                 is_mark, is_space;
`ifdef MORSE_WORD_SPACE_EN
  logic [3:0]           gap_q, gap_d;
`endif

  // ITU Morse lookup; pattern is right-aligned, first symbol MSB-most, dash=1
  function automatic logic [7:0] morse_lut(input logic [2:0] len, input logic [4:0] pat);
    logic [7:0] ch;
    ch = CH_ERR;
    case ({len, pat})
      {3'd2, 5'b00001}: ch = "A";
      {3'd4, 5'b01000}: ch = "B";
      {3'd4, 5'b01010}: ch = "C";
      {3'd3, 5'b00100}: ch = "D";
      {3'd1, 5'b00000}: ch = "E";
      {3'd4, 5'b00010}: ch = "F";
      {3'd3, 5'b00110}: ch = "G";
      {3'd4, 5'b00000}: ch = "H";
      {3'd2, 5'b00000}: ch = "I";
      {3'd4, 5'b00111}: ch = "J";
      {3'd3, 5'b00101}: ch = "K";
      {3'd4, 5'b00100}: ch = "L";
      {3'd2, 5'b00011}: ch = "M";
      {3'd2, 5'b00010}: ch = "N";
      {3'd3, 5'b00111}: ch = "O";
      {3'd4, 5'b00110}: ch = "P";
      {3'd4, 5'b01101}: ch = "Q";
      {3'd3, 5'b00010}: ch = "R";
      {3'd3, 5'b00000}: ch = "S";
      {3'd1, 5'b00001}: ch = "T";
      {3'd3, 5'b00001}: ch = "U";
      {3'd4, 5'b00001}: ch = "V";
      {3'd3, 5'b00011}: ch = "W";
      {3'd4, 5'b01001}: ch = "X";
      {3'd4, 5'b01011}: ch = "Y";
      {3'd4, 5'b01100}: ch = "Z";
      {3'd5, 5'b11111}: ch = "0";
      {3'd5, 5'b01111}: ch = "1";
      {3'd5, 5'b00111}: ch = "2";
      {3'd5, 5'b00011}: ch = "3";
      {3'd5, 5'b00001}: ch = "4";
      {3'd5, 5'b00000}: ch = "5";
      {3'd5, 5'b10000}: ch = "6";
      {3'd5, 5'b11000}: ch = "7";
      {3'd5, 5'b11100}: ch = "8";
      {3'd5, 5'b11110}: ch = "9";
      default:          ch = CH_ERR;
    endcase
    return ch;
  endfunction

  // Bits above the stored length are always zero, so truncation is safe
  assign dec_char = morse_lut(cnt_q, 5'(buf_q));
  assign is_mark  = sym_valid && !sym_in[1];
  assign is_space = sym_valid && (sym_in == 2'b11);

  // Next-state: letter collection and emission scheduling
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    pend_d      = 1'b0;
    pend_char_d = pend_char_q;
    pend_err_d  = 1'b0;
`ifdef MORSE_WORD_SPACE_EN
    gap_d       = gap_q;
`endif
    case (state_q)
      S_IDLE, S_GAP: begin
        if (is_mark) begin
          buf_d   = MAX_SYMS'(sym_in[0]);
          cnt_d   = CNT_W'(1);
          state_d = S_COLLECT;
        end
`ifdef MORSE_WORD_SPACE_EN
        else if (is_space && state_q == S_GAP) begin
          if (gap_q != 4'hF) gap_d = gap_q + 4'd1;
          // Counter passes WORD_GAP-1 only once per gap, so one space char
          if (gap_q == 4'(WORD_GAP - 1)) begin
            pend_d      = 1'b1;
            pend_char_d = 8'h20;
          end
        end
`endif
      end
      S_COLLECT: begin
        if (is_mark) begin
          if (cnt_q == CNT_W'(MAX_SYMS)) begin
            state_d = S_OVERFLOW;
          end else begin
            buf_d = (buf_q << 1) | MAX_SYMS'(sym_in[0]);
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (is_space) begin
          pend_d      = 1'b1;
          pend_char_d = dec_char;
          pend_err_d  = (dec_char == CH_ERR);
          buf_d       = '0;
          cnt_d       = '0;
          state_d     = S_GAP;
`ifdef MORSE_WORD_SPACE_EN
          gap_d       = 4'd0;
`endif
        end
      end
      S_OVERFLOW: begin
        if (is_space) begin
          pend_d      = 1'b1;
          pend_char_d = CH_ERR;
          pend_err_d  = 1'b1;
          buf_d       = '0;
          cnt_d       = '0;
          state_d     = S_GAP;
`ifdef MORSE_WORD_SPACE_EN
          gap_d       = 4'd0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, buffer and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_char_q <= 8'h00;
      pend_err_q  <= 1'b0;
      char_out    <= 8'h00;
      char_valid  <= 1'b0;
      char_err    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_char_q <= pend_char_d;
      pend_err_q  <= pend_err_d;
      char_valid  <= pend_q;
      char_err    <= pend_q & pend_err_q;
      if (pend_q) char_out <= pend_char_q;
      busy        <= (state_d == S_COLLECT) || (state_d == S_OVERFLOW);
    end
  end

`ifdef MORSE_WORD_SPACE_EN
  // Word-gap space counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) gap_q <= 4'd0;
    else     gap_q <= gap_d;
  end
`endif

  assign sym_count = cnt_q;

endmodule

// File: doc/morse_symbol_decoder.md
Name: morse_symbol_decoder

Overview:
- Sits directly downstream of the input processor stage.
- Consumes its 2-bit symbol stream (dot / dash / short space) qualified by a ready strobe.
- Groups dots and dashes into one letter and decodes the letter to 8-bit ASCII (A-Z, 0-9) when a short space arrives.
- Optionally inserts an ASCII space after a sustained gap. Output feeds the display/UART character sink.

Parameters:
- MAX_SYMS, 5, maximum dots/dashes per letter; range 1-7.
- WORD_GAP, 4, consecutive space-symbol cycles after an emitted letter that constitute a word gap (WORD_SPACE_EN only); range 2-15.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- sym_in  input  2  symbol code: 00 dot, 01 dash, 11 short space, 10 none/ignored
- sym_valid  input  1  sym_in qualifier; may stay high on consecutive cycles (repeated 11 during a gap)
- char_out  output  8  decoded ASCII character, held until the next emission
- char_valid  output  1  one-cycle pulse, char_out valid
- char_err  output  1  one-cycle pulse coincident with char_valid when the letter was undecodable or overflowed (char_out = 0x3F '?')
- sym_count  output  3  number of symbols currently buffered (0..MAX_SYMS)
- busy  output  1  high in COLLECT or OVERFLOW

Behaviour:
- Reset values (async, immediate): char_out=0x00, char_valid=0, char_err=0, sym_count=0, busy=0, shift buffer=0, gap counter=0, state=IDLE.
- A symbol is accepted on a rising clk edge with sym_valid=1. Code 10 is always ignored; sym_valid=0 means no event.
- Buffer: pattern register, MAX_SYMS bits, first symbol in the MSB-most used position. Dot=0, dash=1; new symbol shifts in at the LSB.
- States:
  - IDLE: nothing buffered. Dot/dash: store it, sym_count=1, go to COLLECT. Space: ignored.
  - COLLECT: dot/dash with sym_count<MAX_SYMS: append, sym_count+1. Dot/dash with sym_count==MAX_SYMS: go to OVERFLOW, buffer frozen. Space: decode (sym_count, pattern); next cycle pulse char_valid with the ASCII code, clear buffer and sym_count, go to GAP.
  - OVERFLOW: dot/dash discarded. Space: emit 0x3F with char_valid=1 and char_err=1, clear buffer, go to GAP.
  - GAP: dot/dash starts a new letter exactly as in IDLE and goes to COLLECT. Space: gap counter behaves per the optional feature. Other cycles: hold.
- Latency: space accepted at edge N gives char_valid high for the cycle after edge N+1 (one registered stage); exactly one pulse per letter.
- Decode table: ITU Morse, letters A-Z and digits 0-9 only, uppercase ASCII. Any other (length, pattern) gives 0x3F with char_err=1. Table is combinational on registered buffer contents.
- Repeated space symbols never produce more than one letter; a space in IDLE/GAP never emits a letter.
- Simultaneous events: emission and the next dot/dash cannot coincide on one input edge (one symbol per edge). A dot/dash accepted in the cycle char_valid is high is buffered normally.
- Reset mid-letter: partial letter dropped, no emission; a pulse in flight is cancelled.
- char_out keeps the last value between pulses; consumers sample only on char_valid.

Optional Feature:
- Macro: MORSE_WORD_SPACE_EN.
- Defined: in GAP each accepted space increments a saturating 4-bit gap counter (cleared on entry to GAP). When it reaches WORD_GAP, emit 0x20 (char_valid=1, char_err=0) once, then stay in GAP with no further emission until a dot/dash arrives.
- Undefined: gap counter and word-space logic absent; GAP behaves like IDLE; 0x20 never produced.

Test Plan:
- Dot, dash, space (00,01,11 on successive valid cycles) -> single char_valid pulse, char_out=0x41 'A', char_err=0, sym_count back to 0.
- Five dashes then three consecutive spaces -> exactly one pulse, char_out=0x30 '0'; no further pulses.
- Dot,dot,dash,dash,space -> char_out=0x3F, char_err=1 (undefined pattern).
- Six dots then space -> OVERFLOW after 6th dot, sym_count stays 5, one pulse char_out=0x3F with char_err=1.
- MORSE_WORD_SPACE_EN, WORD_GAP=4: dot, space, then 5 more spaces -> 0x45 'E', then exactly one 0x20 pulse on the 4th space after emission; a following dash,space gives 0x54 'T'.
- Dot,dash,dash asserted, rst pulsed mid-letter, then space -> no char_valid, all outputs at reset values, state IDLE.
